// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keyboard event receiver
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } ps2_state_t;

    // Frame layout is {stop, parity, data[7:0], start}; data+parity must have odd weight.
    function automatic logic ps2_frame_ok(input logic [10:0] frame);
        return ~frame[0] & frame[10] & (^frame[9:1]);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - show-ahead synchronous FIFO holding decoded key events
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_valid,
    output logic                       o_wr_ok,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [AW:0]      w_level;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_level   = r_wr - r_rd;
    assign w_full    = (w_level == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & o_valid;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign o_wr_ok   = ~w_full | w_do_pop;
    assign w_do_push = i_push & o_wr_ok;

    assign o_valid = (r_wr != r_rd);
    assign o_level = w_level;
    assign o_rdata = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr[AW-1:0]] <= i_wdata;
                r_wr                <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_event_rx.sv
// rtl/ps2_kbd_event_rx.sv - PS/2 keyboard frame receiver, prefix decoder and event queue
module ps2_kbd_event_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int KCNT_W         = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_brk,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [KCNT_W-1:0]             key_count
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    ps2_state_t             r_state;
    logic [3:0]             r_bitcnt;
    logic [10:0]            r_frame;
    logic [TO_W-1:0]        r_tcnt;
    logic                   r_ext;
    logic                   r_brk;
    logic                   r_frame_err;
    logic                   r_overflow;
    logic [KCNT_W-1:0]      r_key_count;

    logic                   w_fall;
    logic                   w_bit;
    logic                   w_good;
    logic [7:0]             w_byte;
    logic                   w_is_ext;
    logic                   w_is_brk;
    logic                   w_push;
    logic                   w_wr_ok;
    logic                   w_timeout;
    ps2_evt_t               w_evt;
    ps2_evt_t               w_head;

    assign w_fall    = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
    assign w_bit     = r_dat_sync[SYNC_STAGES-2];
    assign w_good    = ps2_frame_ok(r_frame);
    assign w_byte    = r_frame[8:1];
    assign w_is_ext  = (w_byte == PS2_PFX_EXT);
    assign w_is_brk  = (w_byte == PS2_PFX_BRK);
    assign w_push    = (r_state == CHECK) & w_good & ~w_is_ext & ~w_is_brk;
    assign w_evt     = {r_ext, r_brk, w_byte};
    assign w_timeout = (r_state == SHIFT) & ~w_fall & (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            // Lines idle high, so presetting the synchronisers avoids a false fall after reset.
            r_clk_sync  <= '1;
            r_dat_sync  <= '1;
            r_state     <= IDLE;
            r_bitcnt    <= '0;
            r_frame     <= '0;
            r_tcnt      <= '0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tcnt <= '0;
                    if (w_fall && !w_bit) begin
                        r_frame  <= '0;
                        r_bitcnt <= 4'd1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_fall) begin
                        r_frame[r_bitcnt] <= w_bit;
                        r_tcnt            <= '0;
                        if (r_bitcnt == 4'd10) begin
                            r_state <= CHECK;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end else if (w_timeout) begin
                        r_state     <= IDLE;
                        r_frame_err <= 1'b1;
                        r_ext       <= 1'b0;
                        r_brk       <= 1'b0;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                CHECK: begin
                    r_state <= IDLE;
                    if (!w_good) begin
                        r_frame_err <= 1'b1;
                        r_ext       <= 1'b0;
                        r_brk       <= 1'b0;
                    end else if (w_is_ext) begin
                        r_ext <= 1'b1;
                    end else if (w_is_brk) begin
                        r_brk <= 1'b1;
                    end else begin
                        r_ext <= 1'b0;
                        r_brk <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_key_count <= '0;
        end else begin
            if (w_push && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_push && w_wr_ok && r_brk) begin
                r_key_count <= r_key_count + 1'b1;
            end
        end
    end

    ps2_evt_fifo #(
        .WIDTH ($bits(ps2_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_evt),
        .i_pop   (ev_ready),
        .o_rdata (w_head),
        .o_valid (ev_valid),
        .o_wr_ok (w_wr_ok),
        .o_level (fifo_level)
    );

    assign ev_code   = w_head.code;
    assign ev_ext    = w_head.ext;
    assign ev_brk    = w_head.brk;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
    assign key_count = r_key_count;

endmodule

// File: tb/tb_ps2_kbd_event_rx.sv
// tb/tb_ps2_kbd_event_rx.sv - directed-vector bench for ps2_kbd_event_rx
`timescale 1ns/1ps
module tb_ps2_kbd_event_rx;

    localparam int DEPTH = 8;
    localparam int TO    = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic        ev_valid;
    logic        ev_ready;
    logic [7:0]  ev_code;
    logic        ev_ext;
    logic        ev_brk;
    logic [3:0]  fifo_level;
    logic        frame_err;
    logic        overflow;
    logic        ovf_clr;
    logic [15:0] key_count;

    int          n_vec = 0;
    int          n_mis = 0;
    int          n_err = 0;
    logic [9:0]  evq[$];

    always #500 clk = ~clk;

    ps2_kbd_event_rx #(
        .SYNC_STAGES    (3),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO),
        .KCNT_W         (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_brk     (ev_brk),
        .fifo_level (fifo_level),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .key_count  (key_count)
    );

    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) evq.push_back({ev_ext, ev_brk, ev_code});
        if (frame_err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        if (evq.size() == 0) begin
            check({tag, " (no event)"}, 32'hDEAD, 32'(exp));
        end else begin
            got = evq.pop_front();
            check(tag, 32'(got), 32'(exp));
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bit = 80 clk (12.5 kHz at 1 MHz); pulse_rdy raises ev_ready for exactly the push cycle of the stop bit.
    task automatic send_frame(input logic [7:0] b, input int nbits, input bit bad_par,
                              input bit bad_stop, input bit pulse_rdy);
        logic [10:0] f;
        f = {~bad_stop, bad_par ? (^b) : ~(^b), b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            cyc(20);
            ps2_clk = 1'b0;
            if (pulse_rdy && i == 10) begin
                cyc(3);
                ev_ready = 1'b1;
                cyc(1);
                ev_ready = 1'b0;
                cyc(36);
            end else begin
                cyc(40);
            end
            ps2_clk = 1'b1;
            cyc(20);
        end
        ps2_data = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ev_ready = 1'b0; ovf_clr = 1'b0;
        cyc(5);
        check("rst ev_valid", 32'(ev_valid), 0);
        check("rst level", 32'(fifo_level), 0);
        check("rst frame_err", 32'(frame_err), 0);
        check("rst overflow", 32'(overflow), 0);
        check("rst key_count", 32'(key_count), 0);
        check("rst ev_code", 32'(ev_code), 0);
        rst = 1'b0;
        cyc(5);

        // 1: make then break of 1C
        ev_ready = 1'b1;
        send_frame(8'h1C, 11, 0, 0, 0);
        send_frame(8'hF0, 11, 0, 0, 0);
        send_frame(8'h1C, 11, 0, 0, 0);
        cyc(10);
        expect_ev("t1 make 1C", 10'h01C);
        expect_ev("t1 brk 1C", 10'h11C);
        check("t1 key_count", 32'(key_count), 1);

        // 2: extended make/break, then plain key
        send_frame(8'hE0, 11, 0, 0, 0);
        send_frame(8'h75, 11, 0, 0, 0);
        send_frame(8'hE0, 11, 0, 0, 0);
        send_frame(8'hF0, 11, 0, 0, 0);
        send_frame(8'h75, 11, 0, 0, 0);
        send_frame(8'h1C, 11, 0, 0, 0);
        cyc(10);
        expect_ev("t2 ext make 75", 10'h275);
        expect_ev("t2 ext brk 75", 10'h375);
        expect_ev("t2 plain 1C", 10'h01C);
        check("t2 key_count", 32'(key_count), 2);
        check("t1t2 no frame_err", 32'(n_err), 0);

        // 3: bad parity, bad stop on F0, then 1C must be a make
        send_frame(8'h1C, 11, 1, 0, 0);
        cyc(10);
        check("t3 parity err", 32'(n_err), 1);
        check("t3 parity no event", 32'(evq.size()), 0);
        send_frame(8'hF0, 11, 0, 1, 0);
        send_frame(8'h1C, 11, 0, 0, 0);
        cyc(10);
        check("t3 stop err", 32'(n_err), 2);
        expect_ev("t3 1C after err", 10'h01C);
        check("t3 one event only", 32'(evq.size()), 0);
        check("t3 key_count", 32'(key_count), 2);

        // 4: overflow with consumer stalled
        ev_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) send_frame(8'h16 + 8'(8 * i), 11, 0, 0, 0);
        cyc(10);
        check("t4 level full", 32'(fifo_level), DEPTH);
        check("t4 overflow", 32'(overflow), 1);
        check("t4 head", 32'(ev_code), 32'h16);
        ev_ready = 1'b1;
        cyc(20);
        for (int i = 0; i < DEPTH; i++) expect_ev($sformatf("t4 drain %0d", i), 10'(8'h16 + 8'(8 * i)));
        check("t4 drained", 32'(evq.size()), 0);
        check("t4 level empty", 32'(fifo_level), 0);
        check("t4 overflow sticky", 32'(overflow), 1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        check("t4 ovf_clr", 32'(overflow), 0);

        // 5: truncated frame times out
        send_frame(8'h1C, 5, 0, 0, 0);
        cyc(TO + 100);
        check("t5 timeout err", 32'(n_err), 3);
        check("t5 no event", 32'(evq.size()), 0);
        send_frame(8'h1C, 11, 0, 0, 0);
        cyc(10);
        expect_ev("t5 1C after timeout", 10'h01C);

        // 6: push and pop coincide on a full FIFO, then reset mid-frame
        ev_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_frame(8'h16 + 8'(8 * i), 11, 0, 0, 0);
        cyc(10);
        check("t6 level full", 32'(fifo_level), DEPTH);
        send_frame(8'h66, 11, 0, 0, 1);
        cyc(5);
        check("t6 level kept", 32'(fifo_level), DEPTH);
        check("t6 no overflow", 32'(overflow), 0);
        check("t6 new head", 32'(ev_code), 32'h1E);
        expect_ev("t6 popped", 10'h016);
        send_frame(8'h2E, 5, 0, 0, 0);
        rst = 1'b1;
        cyc(2);
        check("t6 rst ev_valid", 32'(ev_valid), 0);
        check("t6 rst level", 32'(fifo_level), 0);
        check("t6 rst overflow", 32'(overflow), 0);
        check("t6 rst key_count", 32'(key_count), 0);
        check("t6 rst ev_code", 32'({ev_ext, ev_brk, ev_code}), 0);
        rst = 1'b0;
        cyc(TO + 50);
        check("t6 no frame_err", 32'(n_err), 3);
        check("t6 ev_valid idle", 32'(ev_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
